// File: rtl/btn_shift_amt_ctrl_if.sv
// ----------------------------------------------------------------------------
// btn_shift_amt_ctrl_if
// Groups the button inputs and the shift-amount outputs of btn_shift_amt_ctrl.
//   btn_n   [1:0]        raw active-low pushbuttons (asynchronous to clk)
//   btn_db  [1:0]        debounced button levels, active-high
//   amt     [AMT_W-1:0]  current shift amount
//   amt_chg              one-cycle strobe when amt takes a new value
// Modports:
//   master : the side that drives the buttons and observes amt
//   slave  : the controller itself
// ----------------------------------------------------------------------------
interface btn_shift_amt_ctrl_if #(
    parameter int unsigned AMT_W = 3
);
    logic [1:0]       btn_n;
    logic [1:0]       btn_db;
    logic [AMT_W-1:0] amt;
    logic             amt_chg;

    modport master (
        output btn_n,
        input  btn_db,
        input  amt,
        input  amt_chg
    );

    modport slave (
        input  btn_n,
        output btn_db,
        output amt,
        output amt_chg
    );
endinterface

// File: rtl/btn_shift_amt_ctrl.sv
// ----------------------------------------------------------------------------
// btn_shift_amt_ctrl
// Control stage for the barrel-shifter demo. Two raw active-low pushbuttons
// are synchronised, debounced and edge-detected, with auto-repeat while held.
// A wrapping shift-amount register is stepped up by button 0 and down by
// button 1.
// Ports:
//   clk      system clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      btn_shift_amt_ctrl_if.slave
//              btn_n   (in)  raw buttons, active-low
//              btn_db  (out) debounced levels, active-high
//              amt     (out) shift amount, modulo 2**AMT_W
//              amt_chg (out) high in the cycle amt takes a new value
// ----------------------------------------------------------------------------
module btn_shift_amt_ctrl #(
    parameter int unsigned AMT_W     = 3,
    parameter int unsigned DB_TICKS  = 1000000,
    parameter int unsigned REP_DELAY = 25000000,
    parameter int unsigned REP_RATE  = 5000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    btn_shift_amt_ctrl_if.slave  bus
);

    localparam int unsigned DB_CW    = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam int unsigned HOLD_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int unsigned HOLD_CW  = $clog2(HOLD_MAX + 1);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } db_state_t;

    logic [1:0]       w_btn_db;
    logic [1:0]       w_press;
    logic [1:0]       w_rep;
    logic             w_both;
    logic             w_up;
    logic             w_dn;
    logic [AMT_W-1:0] r_amt;
    logic             r_amt_chg;

    // Holding both buttons masks auto-repeat on both of them.
    assign w_both = w_btn_db[0] & w_btn_db[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]         r_sync;
            logic               w_btn_s;
            db_state_t          r_state;
            logic               r_state_d;
            logic [DB_CW-1:0]   r_cnt;
            logic [HOLD_CW-1:0] r_hold;
            logic               r_repeating;
            logic               w_state_on;
            logic               w_rep_hit;

            // Synchroniser resets to the released level so a button held
            // through reset is seen as a fresh press afterwards.
            assign w_btn_s    = ~r_sync[1];
            assign w_state_on = (r_state == PRESSED);

            // First repeat after REP_DELAY cycles of hold, then every REP_RATE.
            assign w_rep_hit  = w_state_on &&
                                (r_repeating ? (r_hold == HOLD_CW'(REP_RATE))
                                             : (r_hold == HOLD_CW'(REP_DELAY)));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync      <= 2'b11;
                    r_state     <= RELEASED;
                    r_state_d   <= 1'b0;
                    r_cnt       <= '0;
                    r_hold      <= '0;
                    r_repeating <= 1'b0;
                end else begin
                    r_sync    <= {r_sync[0], bus.btn_n[gi]};
                    r_state_d <= w_state_on;

                    // Debounce: the synchronised level must disagree with
                    // the accepted state for DB_TICKS consecutive cycles.
                    case (r_state)
                        RELEASED: begin
                            if (!w_btn_s) begin
                                r_cnt <= '0;
                            end else if (r_cnt == DB_CW'(DB_TICKS - 1)) begin
                                r_state <= PRESSED;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        PRESSED: begin
                            if (w_btn_s) begin
                                r_cnt <= '0;
                            end else if (r_cnt == DB_CW'(DB_TICKS - 1)) begin
                                r_state <= RELEASED;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        default: begin
                            r_state <= RELEASED;
                            r_cnt   <= '0;
                        end
                    endcase

                    // Hold timer: zero in the press cycle, counts cycles held.
                    if (!w_state_on) begin
                        r_hold      <= '0;
                        r_repeating <= 1'b0;
                    end else if (w_rep_hit) begin
                        r_hold      <= HOLD_CW'(1);
                        r_repeating <= 1'b1;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
            end

            assign w_btn_db[gi] = w_state_on;
            assign w_press[gi]  = w_state_on & ~r_state_d;
            assign w_rep[gi]    = w_rep_hit & ~w_both;
        end
    endgenerate

    assign w_up = w_press[0] | w_rep[0];
    assign w_dn = w_press[1] | w_rep[1];

    // Simultaneous up and down requests cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_amt     <= '0;
            r_amt_chg <= 1'b0;
        end else begin
            r_amt_chg <= w_up ^ w_dn;
            case ({w_dn, w_up})
                2'b01:   r_amt <= r_amt + 1'b1;
                2'b10:   r_amt <= r_amt - 1'b1;
                default: r_amt <= r_amt;
            endcase
        end
    end

    assign bus.btn_db  = w_btn_db;
    assign bus.amt     = r_amt;
    assign bus.amt_chg = r_amt_chg;

endmodule

// File: tb/tb_btn_shift_amt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_btn_shift_amt_ctrl
// Scoreboard bench for btn_shift_amt_ctrl with small timing parameters.
// Tasks push the amt values each expected step should produce; a monitor
// pops one entry on every amt_chg strobe and also flags any amt change
// that happens without a strobe.
// ----------------------------------------------------------------------------
module tb_btn_shift_amt_ctrl;
    localparam int unsigned AMT_W     = 3;
    localparam int unsigned DB_TICKS  = 4;
    localparam int unsigned REP_DELAY = 16;
    localparam int unsigned REP_RATE  = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    btn_shift_amt_ctrl_if #(.AMT_W(AMT_W)) bus ();

    btn_shift_amt_ctrl #(
        .AMT_W     (AMT_W),
        .DB_TICKS  (DB_TICKS),
        .REP_DELAY (REP_DELAY),
        .REP_RATE  (REP_RATE)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int chg_count = 0;
    logic [AMT_W-1:0] exp_q[$];
    logic [AMT_W-1:0] prev_amt = '0;

    // Monitor samples on the falling edge; stimulus moves 2 ns after rising.
    always @(negedge clk) begin
        logic [AMT_W-1:0] exp_amt;
        if (reset_n === 1'b1) begin
            if (bus.amt_chg === 1'b1) begin
                chg_count++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL step_unexpected: amt=%0d, required no step", bus.amt);
                end else begin
                    exp_amt = exp_q.pop_front();
                    $display("step: amt=%0d expected=%0d", bus.amt, exp_amt);
                    if (bus.amt !== exp_amt) begin
                        n_miss++;
                        $display("FAIL step_value: amt=%0d, required %0d", bus.amt, exp_amt);
                    end
                end
            end else if (bus.amt !== prev_amt) begin
                n_vec++;
                n_miss++;
                $display("FAIL amt_no_strobe: amt=%0d, required %0d", bus.amt, prev_amt);
            end
        end
        prev_amt = bus.amt;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL %s_missing_steps: %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_amt(input string name, input logic [AMT_W-1:0] exp_amt);
        n_vec++;
        $display("%s: amt=%0d expected=%0d", name, bus.amt, exp_amt);
        if (bus.amt !== exp_amt) begin
            n_miss++;
            $display("FAIL %s: amt=%0d, required %0d", name, bus.amt, exp_amt);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic press(input int b, input int hold);
        bus.btn_n[b] = 1'b0;
        repeat (hold) tick();
        bus.btn_n[b] = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        int start_chg;
        bus.btn_n = 2'b11;
        reset_n   = 1'b0;
        tick();
        tick();
        n_vec++;
        if (bus.amt !== 3'd0 || bus.btn_db !== 2'b00 || bus.amt_chg !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state: amt=%0d btn_db=%b amt_chg=%b, required 0 00 0",
                     bus.amt, bus.btn_db, bus.amt_chg);
        end
        reset_n = 1'b1;
        start_chg = chg_count;
        repeat (20) tick();
        n_vec++;
        if (chg_count != start_chg || bus.btn_db !== 2'b00) begin
            n_miss++;
            $display("FAIL reset_idle: strobes=%0d btn_db=%b, required 0 00",
                     chg_count - start_chg, bus.btn_db);
        end
        check_amt("reset_idle_amt", 3'd0);
    endtask

    task automatic test_latency();
        int lat = 0;
        exp_q.push_back(3'd1);
        bus.btn_n[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (lat == 0 && bus.amt === 3'd1) begin
                lat = k;
                n_vec++;
                if (bus.amt_chg !== 1'b1) begin
                    n_miss++;
                    $display("FAIL latency_strobe: amt_chg=%b, required 1", bus.amt_chg);
                end
            end
            if (k == 10) bus.btn_n[0] = 1'b1;
        end
        n_vec++;
        $display("latency: edges=%0d expected=7", lat);
        if (lat != 7) begin
            n_miss++;
            $display("FAIL latency_edges: %0d, required 7", lat);
        end
        repeat (20) tick();
        check_amt("latency_after_release", 3'd1);
        check_drained("latency");
    endtask

    task automatic test_bounce();
        logic seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.btn_n[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (bus.btn_db[0] === 1'b1) seen = 1'b1;
        end
        bus.btn_n[0] = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (seen !== 1'b0) begin
            n_miss++;
            $display("FAIL bounce_db: btn_db[0] went high, required never");
        end
        check_amt("bounce_amt", 3'd1);
    endtask

    task automatic test_wrap();
        do_reset();
        check_amt("wrap_start", 3'd0);
        exp_q.push_back(3'd7);
        press(1, 10);
        check_amt("wrap_down", 3'd7);
        exp_q.push_back(3'd0);
        press(0, 10);
        exp_q.push_back(3'd1);
        press(0, 10);
        check_amt("wrap_up", 3'd1);
        check_drained("wrap");
    endtask

    task automatic test_repeat();
        do_reset();
        // press step + repeats at +16, +24, +32, +40, +48, +56
        for (int i = 1; i <= 7; i++) exp_q.push_back(AMT_W'(i));
        bus.btn_n[0] = 1'b0;
        repeat (58) tick();
        bus.btn_n[0] = 1'b1;
        repeat (20) tick();
        check_amt("repeat_final", 3'd7);
        check_drained("repeat");
    endtask

    task automatic test_both_and_reset();
        int start_chg = chg_count;
        bus.btn_n = 2'b00;
        repeat (40) tick();
        n_vec++;
        if (chg_count != start_chg || bus.btn_db !== 2'b11) begin
            n_miss++;
            $display("FAIL both_held: strobes=%0d btn_db=%b, required 0 11",
                     chg_count - start_chg, bus.btn_db);
        end
        check_amt("both_held_amt", 3'd7);
        reset_n = 1'b0;
        #1;
        check_amt("async_reset_amt", 3'd0);
        n_vec++;
        if (bus.btn_db !== 2'b00) begin
            n_miss++;
            $display("FAIL async_reset_db: btn_db=%b, required 00", bus.btn_db);
        end
        bus.btn_n[1] = 1'b1;
        tick();
        tick();
        exp_q.push_back(3'd1);
        reset_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 12) bus.btn_n[0] = 1'b1;
        end
        check_amt("reset_midpress_amt", 3'd1);
        check_drained("reset_midpress");
    endtask

    initial begin
        bus.btn_n = 2'b11;
        reset_n   = 1'b0;
        test_reset();
        test_latency();
        test_bounce();
        test_wrap();
        test_repeat();
        test_both_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
